// File: rtl/fibonacci_index_finder.sv
// Fibonacci index finder: for an input value, iterates fib(k) upward and reports
// the largest n with fib(n) <= value, plus whether the value is exactly fib(n).
// Ports:
//   clk_i, reset_i       clock, asynchronous active-high reset
//   start_i, value_i     request and value, sampled only while ready_o=1
//   ready_o              high exactly while idle
//   done_o               one-cycle pulse when results are valid
//   index_o, exact_o     largest index and exact-match flag (held until next start)
//   range_err_o          value exceeded MAX_VALUE (held until next start)
module fibonacci_index_finder #(
  parameter int unsigned VALUE_W   = 14,
  parameter int unsigned INDEX_W   = 7,
  parameter int unsigned MAX_VALUE = 9999
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [VALUE_W-1:0] value_i,
  output logic               ready_o,
  output logic               done_o,
  output logic [INDEX_W-1:0] index_o,
  output logic               exact_o,
  output logic               range_err_o
);

  localparam logic [VALUE_W-1:0] MAX_V = VALUE_W'(MAX_VALUE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state;
  logic [VALUE_W:0]   a;    // fib(k)
  logic [VALUE_W:0]   b;    // fib(k+1); extra bit keeps a+b from wrapping
  logic [INDEX_W-1:0] k;
  logic [VALUE_W-1:0] val;

  logic [VALUE_W:0]   val_ext;
  assign val_ext = {1'b0, val};

  // Search FSM with registered handshake and result outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      a           <= '0;
      b           <= '0;
      k           <= '0;
      val         <= '0;
      ready_o     <= 1'b1;
      done_o      <= 1'b0;
      index_o     <= '0;
      exact_o     <= 1'b0;
      range_err_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            val         <= value_i;
            index_o     <= '0;
            exact_o     <= 1'b0;
            range_err_o <= 1'b0;
            ready_o     <= 1'b0;
            if (value_i > MAX_V) begin
              range_err_o <= 1'b1;
              done_o      <= 1'b1;
              state       <= DONE;
            end else begin
              a     <= '0;
              b     <= (VALUE_W+1)'(1);
              k     <= '0;
              state <= SEARCH;
            end
          end
        end
        SEARCH: begin
          // b overtaking val means a=fib(k) is the largest fib <= val
          if (b > val_ext) begin
            index_o <= k;
            exact_o <= (a == val_ext);
            done_o  <= 1'b1;
            state   <= DONE;
          end else begin
            a <= b;
            b <= a + b;
            k <= k + INDEX_W'(1);
          end
        end
        DONE: begin
          ready_o <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_o <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_index_finder.sv
// Directed bench for fibonacci_index_finder: latency, results, range error,
// continuous start, and asynchronous reset mid-search.
module tb_fibonacci_index_finder;

  logic        clk_i;
  logic        reset_i;
  logic        start_i;
  logic [13:0] value_i;
  logic        ready_o;
  logic        done_o;
  logic [6:0]  index_o;
  logic        exact_o;
  logic        range_err_o;

  int n_cmp;
  int n_err;

  fibonacci_index_finder dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .value_i     (value_i),
    .ready_o     (ready_o),
    .done_o      (done_o),
    .index_o     (index_o),
    .exact_o     (exact_o),
    .range_err_o (range_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE and check latency and results
  task automatic run_value(input string tag, input logic [13:0] v, input int exp_idx,
                           input int exp_exact, input int exp_err, input int exp_lat);
    int cnt;
    bit seen;
    @(negedge clk_i);
    check_eq({tag, " ready"}, 32'(ready_o), 32'd1);
    start_i = 1'b1;
    value_i = v;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    cnt  = 0;
    seen = 0;
    while (!seen && cnt < 40) begin
      @(negedge clk_i);
      cnt++;
      if (done_o) seen = 1;
    end
    check_eq({tag, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check_eq({tag, " latency"},   32'(cnt),         32'(exp_lat));
      check_eq({tag, " index"},     32'(index_o),     32'(exp_idx));
      check_eq({tag, " exact"},     32'(exact_o),     32'(exp_exact));
      check_eq({tag, " range_err"}, 32'(range_err_o), 32'(exp_err));
      check_eq({tag, " ready_in_done"}, 32'(ready_o), 32'd0);
      @(negedge clk_i);
      check_eq({tag, " ready_after"}, 32'(ready_o), 32'd1);
      check_eq({tag, " done_pulse"},  32'(done_o),  32'd0);
      check_eq({tag, " index_hold"},  32'(index_o), 32'(exp_idx));
    end
  endtask

  initial begin
    int f0, f1, ft;
    int cnt, ndone;
    bit second_sent;
    n_cmp   = 0;
    n_err   = 0;
    start_i = 1'b0;
    value_i = '0;
    reset_i = 1'b1;
    #3;
    check_eq("rst ready", 32'(ready_o), 32'd1);
    check_eq("rst done",  32'(done_o),  32'd0);
    check_eq("rst index", 32'(index_o), 32'd0);
    check_eq("rst exact", 32'(exact_o), 32'd0);
    check_eq("rst rerr",  32'(range_err_o), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_eq("idle ready", 32'(ready_o), 32'd1);
    check_eq("idle done",  32'(done_o),  32'd0);

    run_value("v0",     14'd0,     0,  1, 0, 2);
    run_value("v4",     14'd4,     4,  0, 0, 6);
    run_value("v6765",  14'd6765,  20, 1, 0, 22);
    run_value("v9999",  14'd9999,  20, 0, 0, 22);
    run_value("v10000", 14'd10000, 0,  0, 1, 1);
    run_value("v1",     14'd1,     2,  1, 0, 4);
    run_value("v2",     14'd2,     3,  1, 0, 5);

    // Round trip: fib(n) for n=0 and n=2..20 must decode back to n
    f0 = 0;
    f1 = 1;
    for (int n = 0; n <= 20; n++) begin
      if (n != 1) run_value($sformatf("rt%0d", n), 14'(f0), n, 1, 0, n + 2);
      ft = f0 + f1;
      f0 = f1;
      f1 = ft;
    end

    // Continuous start: only values sampled in IDLE matter
    @(negedge clk_i);
    start_i     = 1'b1;
    value_i     = 14'd5;
    second_sent = 0;
    ndone       = 0;
    @(posedge clk_i);
    cnt = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk_i);
      cnt++;
      if (done_o) begin
        ndone++;
        if (ndone == 1) begin
          check_eq("cont done1 cycle", 32'(cnt), 32'd7);
          check_eq("cont idx1",   32'(index_o), 32'd5);
          check_eq("cont exact1", 32'(exact_o), 32'd1);
        end else begin
          check_eq("cont done2 cycle", 32'(cnt), 32'd16);
          check_eq("cont idx2",   32'(index_o), 32'd6);
          check_eq("cont exact2", 32'(exact_o), 32'd1);
        end
      end
      if (ready_o && !second_sent) begin
        value_i     = 14'd8;
        second_sent = 1;
      end else if (ready_o) begin
        start_i = 1'b0;
      end else begin
        value_i = 14'((cnt * 613) % 9000);
      end
    end
    check_eq("cont ndone", 32'(ndone), 32'd2);
    start_i = 1'b0;

    // Asynchronous reset mid-search aborts with no done pulse
    @(negedge clk_i);
    start_i = 1'b1;
    value_i = 14'd6765;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    check_eq("arst ready", 32'(ready_o), 32'd1);
    check_eq("arst done",  32'(done_o),  32'd0);
    check_eq("arst index", 32'(index_o), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk_i);
      if (done_o) ndone++;
    end
    check_eq("arst no_done", 32'(ndone), 32'd0);
    check_eq("arst idle ready", 32'(ready_o), 32'd1);
    run_value("post8", 14'd8, 6, 1, 0, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
